// File: rtl/flow_light_pkg.sv
// rtl/flow_light_pkg.sv - shared motion/style encodings for the running-light generator
package flow_light_pkg;

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_HOME   = 3'b001;
    localparam logic [2:0] MODE_FWD    = 3'b010;
    localparam logic [2:0] MODE_REV    = 3'b011;
    localparam logic [2:0] MODE_BOUNCE = 3'b100;

    localparam logic STYLE_DOT = 1'b0;
    localparam logic STYLE_BAR = 1'b1;

endpackage

// File: rtl/flow_light_gen_step_prescaler.sv
// rtl/flow_light_gen_step_prescaler.sv - step prescaler, Step is high in cycles where cnt has reached Div
module step_prescaler #(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 CLK_in,
    input  logic                 RST_in,
    input  logic                 Clear,
    input  logic [DIV_WIDTH-1:0] Div,
    output logic                 Step
);

    logic [DIV_WIDTH-1:0] cnt;

    // >= rather than == so a Div lowered below cnt still fires promptly
    assign Step = (cnt >= Div);

    always_ff @(posedge CLK_in) begin
        if (RST_in || Clear || Step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flow_light_gen.sv
// rtl/flow_light_gen.sv - parametrised running-light generator with dot/bar styles and bounce motion
module flow_light_gen
    import flow_light_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIV_WIDTH = 24,
    parameter int POS_W     = $clog2(WIDTH)
) (
    input  logic                 CLK_in,
    input  logic                 RST_in,
    input  logic [2:0]           Mode,
    input  logic                 Style,
    input  logic [DIV_WIDTH-1:0] Div,
    output logic [WIDTH-1:0]     Light,
    output logic [POS_W-1:0]     Pos,
    output logic                 Tick
);

    localparam logic [POS_W-1:0] P_MAX  = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] P_NEAR = POS_W'(WIDTH - 2);
    localparam logic [POS_W-1:0] P_ONE  = POS_W'(1);

    logic             step;
    logic             home;
    logic             moving;
    logic [POS_W-1:0] p;
    logic [POS_W-1:0] p_nxt;
    logic             dir;
    logic             dir_nxt;
    logic [WIDTH-1:0] light_nxt;

    assign home   = (Mode == MODE_HOME);
    assign moving = (Mode == MODE_FWD) || (Mode == MODE_REV) || (Mode == MODE_BOUNCE);

    step_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
        .CLK_in (CLK_in),
        .RST_in (RST_in),
        .Clear  (home),
        .Div    (Div),
        .Step   (step)
    );

    // Wraps are explicit because WIDTH need not be a power of two
    always_comb begin
        p_nxt   = p;
        dir_nxt = dir;
        if (home) begin
            p_nxt   = '0;
            dir_nxt = 1'b0;
        end else if (step) begin
            case (Mode)
                MODE_FWD: p_nxt = (p == P_MAX) ? '0 : p + P_ONE;
                MODE_REV: p_nxt = (p == '0) ? P_MAX : p - P_ONE;
                MODE_BOUNCE: begin
                    if (!dir) begin
                        if (p == P_MAX) begin
                            dir_nxt = 1'b1;
                            p_nxt   = P_NEAR;
                        end else begin
                            p_nxt = p + P_ONE;
                        end
                    end else begin
                        if (p == '0) begin
                            dir_nxt = 1'b0;
                            p_nxt   = P_ONE;
                        end else begin
                            p_nxt = p - P_ONE;
                        end
                    end
                end
                default: p_nxt = p;
            endcase
        end
    end

    // Bit i sits (WIDTH-1-i) positions away from the MSB end
    always_comb begin
        light_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Style == STYLE_BAR) begin
                light_nxt[i] = ((WIDTH - 1 - i) <= int'(p_nxt));
            end else begin
                light_nxt[i] = ((WIDTH - 1 - i) == int'(p_nxt));
            end
        end
    end

    always_ff @(posedge CLK_in) begin
        if (RST_in) begin
            p     <= '0;
            dir   <= 1'b0;
            Tick  <= 1'b0;
            Light <= {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            p     <= p_nxt;
            dir   <= dir_nxt;
            Tick  <= step && moving;
            Light <= light_nxt;
        end
    end

    assign Pos = p;

endmodule

// File: tb/tb_flow_light_gen.sv
// tb/tb_flow_light_gen.sv - directed and randomized checks of flow_light_gen against a behavioural model
module tb_flow_light_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        style;
    logic [7:0]  div;

    logic [15:0] light16;
    logic [3:0]  pos16;
    logic        tick16;
    logic [4:0]  light5;
    logic [2:0]  pos5;
    logic        tick5;

    int total = 0;
    int bad   = 0;

    int m_p[2];
    int m_dir[2];
    int m_cnt[2];
    int m_tick[2];
    int m_w[2] = '{16, 5};

    always #5 clk = ~clk;

    flow_light_gen #(.WIDTH(16), .DIV_WIDTH(8)) dut16 (
        .CLK_in(clk), .RST_in(rst), .Mode(mode), .Style(style), .Div(div),
        .Light(light16), .Pos(pos16), .Tick(tick16)
    );

    flow_light_gen #(.WIDTH(5), .DIV_WIDTH(8)) dut5 (
        .CLK_in(clk), .RST_in(rst), .Mode(mode), .Style(style), .Div(div),
        .Light(light5), .Pos(pos5), .Tick(tick5)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_light(input int w, input int p, input int bar);
        logic [63:0] ones;
        ones = (64'd1 << (p + 1)) - 64'd1;
        if (bar != 0) return ones << (w - 1 - p);
        return 64'd1 << (w - 1 - p);
    endfunction

    // Model: position as a plain integer moved by modular arithmetic each step
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int w;
            int fire;
            w = m_w[k];
            if (rst) begin
                m_p[k] = 0; m_dir[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
            end else if (mode == 3'd1) begin
                m_p[k] = 0; m_dir[k] = 0; m_cnt[k] = 0; m_tick[k] = 0;
            end else begin
                fire = (m_cnt[k] >= int'(div));
                m_cnt[k] = fire ? 0 : m_cnt[k] + 1;
                m_tick[k] = fire && (mode == 3'd2 || mode == 3'd3 || mode == 3'd4);
                if (fire) begin
                    if (mode == 3'd2) m_p[k] = (m_p[k] + 1) % w;
                    else if (mode == 3'd3) m_p[k] = (m_p[k] + w - 1) % w;
                    else if (mode == 3'd4) begin
                        if (m_dir[k] == 0 && m_p[k] == w - 1) m_dir[k] = 1;
                        else if (m_dir[k] == 1 && m_p[k] == 0) m_dir[k] = 0;
                        m_p[k] = m_p[k] + ((m_dir[k] == 0) ? 1 : -1);
                    end
                end
            end
        end
    endtask

    logic reset_seen = 1'b0;

    task automatic cyc();
        logic [63:0] l16;
        logic [63:0] l5;
        logic        was_rst;
        @(posedge clk);
        was_rst = rst;
        model_edge();
        if (was_rst) reset_seen = 1'b1;
        #1;
        if (reset_seen) begin
            l16 = was_rst ? 64'h8000 : exp_light(16, m_p[0], int'(style));
            l5  = was_rst ? 64'h10   : exp_light(5,  m_p[1], int'(style));
            check("light16", 64'(light16), l16);
            check("pos16",   64'(pos16),   64'(m_p[0]));
            check("tick16",  64'(tick16),  64'(m_tick[0]));
            check("light5",  64'(light5),  l5);
            check("pos5",    64'(pos5),    64'(m_p[1]));
            check("tick5",   64'(tick5),   64'(m_tick[1]));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        rst = 1'b0;
    endtask

    initial begin
        int bounce_seq[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
        int waited;

        rst = 1'b1; mode = 3'd0; style = 1'b0; div = 8'd0;

        do_reset(2);
        check("reset_light", 64'(light16), 64'h8000);
        check("reset_pos",   64'(pos16),   64'd0);
        check("reset_tick",  64'(tick16),  64'd0);

        mode = 3'd2; div = 8'd0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            check("fwd_pos", 64'(pos16), 64'(i % 16));
            check("fwd_tick", 64'(tick16), 64'd1);
            if (i == 15) check("fwd_light_lsb", 64'(light16), 64'h0001);
            if (i == 16) check("fwd_light_wrap", 64'(light16), 64'h8000);
        end

        do_reset(1);
        mode = 3'd3; div = 8'd3;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("rev_no_tick", 64'(tick16), 64'd0);
        end
        cyc();
        check("rev_first_pos", 64'(pos16), 64'd15);
        check("rev_first_light", 64'(light16), 64'h0001);
        check("rev_first_tick", 64'(tick16), 64'd1);
        for (int i = 0; i < 4; i++) cyc();
        check("rev_second_pos", 64'(pos16), 64'd14);

        do_reset(1);
        mode = 3'd4; div = 8'd0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("bounce5_pos", 64'(pos5), 64'(bounce_seq[i]));
        end

        do_reset(1);
        mode = 3'd2; div = 8'd0; style = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("bar_pos", 64'(pos16), 64'd3);
        check("bar_light", 64'(light16), 64'hF000);
        mode = 3'd0; style = 1'b0;
        cyc();
        check("dot_light", 64'(light16), 64'h1000);
        check("dot_pos", 64'(pos16), 64'd3);

        for (int pass = 0; pass < 2; pass++) begin
            do_reset(1);
            mode = 3'd2; div = 8'd9;
            for (int i = 0; i < 5; i++) cyc();
            if (pass == 0) begin
                mode = 3'd1;
                cyc();
                check("home_pos", 64'(pos16), 64'd0);
                mode = 3'd2;
            end else begin
                do_reset(1);
            end
            waited = 0;
            do begin
                cyc();
                waited++;
            end while (!tick16 && waited < 40);
            check(pass == 0 ? "home_tick_gap" : "rst_tick_gap", 64'(waited), 64'd10);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) style = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) div = 8'($urandom_range(0, 6));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flow_light_gen.md
# flow_light_gen

Parametrised running-light generator for the board LED bank. It supersedes the fixed 16-LED, single-speed display with configurable width, a built-in step prescaler, bounce motion and a bar-graph style. It sits between the switch/button decoding logic and the LED output pins. Position and step-tick outputs are exported for the seven-segment and debug logic.

## Interface
Parameters:
- WIDTH, 16, number of LEDs driven; legal range 2..64.
- DIV_WIDTH, 24, width of the prescaler reload value.
- POS_W, $clog2(WIDTH), width of the position output; derived, not to be overridden.

Ports:
- CLK_in, input, 1, the single system clock; all state changes on its rising edge.
- RST_in, input, 1, synchronous, active-high reset.
- Mode, input, 3, motion command (encodings below).
- Style, input, 1, 0 = dot (one-hot), 1 = bar (thermometer).
- Div, input, DIV_WIDTH, prescaler value; a step occurs every Div+1 cycles.
- Light, output, WIDTH, LED drive, registered.
- Pos, output, POS_W, current position 0..WIDTH-1, registered.
- Tick, output, 1, one-cycle pulse, high in the cycle after each position update.

## Operation
- Position p = 0 lights bit WIDTH-1 (MSB). Increasing p moves the lit LED toward the LSB.
- Dot style: Light = 1 << (WIDTH-1-p).
- Bar style: bits WIDTH-1 down to WIDTH-1-p are set. Example: p = 3, WIDTH = 16 gives 16'hF000.
- Mode encodings:
  - 000 HOLD: p frozen; prescaler keeps counting but does not step.
  - 001 HOME: p <= 0, prescaler count <= 0 and bounce direction <= forward, on every cycle the mode is held. Acts immediately and does not wait for a step.
  - 010 FWD: p <= p+1 per step; WIDTH-1 wraps to 0.
  - 011 REV: p <= p-1 per step; 0 wraps to WIDTH-1.
  - 100 BOUNCE: moves in the internal direction bit. At p = WIDTH-1 while moving forward, the direction flips and the same step goes to WIDTH-2. At p = 0 while moving reverse, it flips and goes to 1. The internal direction bit is only updated in BOUNCE and HOME.
  - 101, 110, 111: reserved; behave as HOLD.
- Prescaler: counter cnt (DIV_WIDTH bits).
  - A step fires when cnt >= Div; cnt then reloads to 0. Otherwise cnt <= cnt+1.
  - Div = 0 steps every cycle.
  - Reducing Div below the current cnt fires a step on the next cycle.
- Style is purely a decode of p. Changing Style updates Light one cycle later and never moves p.
- Arithmetic: p wrap is explicit. No reliance on POS_W overflow, because WIDTH need not be a power of two.

## Timing
- Reset values (the cycle after RST_in is sampled high):
  - p = 0, cnt = 0, bounce direction = forward, Tick = 0.
  - Light = MSB only (1 << (WIDTH-1)) in either style. Bar style with p = 0 also yields MSB only.
- RST_in takes priority over Mode. Asserting reset mid-count discards the partial count.
- Step latency:
  - Step decision is made in cycle n, and p updates at the edge ending cycle n.
  - Light, Pos and Tick all reflect the new p in cycle n+1.
  - With Div = D, consecutive Tick pulses are exactly D+1 cycles apart.
- Mode change: sampled every cycle and affects the next step only. It does not reset cnt, except HOME.
- Leaving HOME: the first step occurs Div+1 cycles after the last HOME cycle.

## Structure
- Package flow_light_pkg holds:
  - mode localparams MODE_HOLD, MODE_HOME, MODE_FWD, MODE_REV, MODE_BOUNCE;
  - style constants STYLE_DOT and STYLE_BAR.
- Sub-module step_prescaler (parameter DIV_WIDTH; ports CLK_in, RST_in, Clear, Div, Step) owns cnt. HOME drives its Clear input.
- The top level holds p, the direction bit and the registered Light/Tick decode.

## Test plan
- Reset with RST_in = 1 for 2 cycles, WIDTH = 16 → Light = 16'h8000, Pos = 0, Tick = 0.
- FWD, Div = 0, 16 cycles → Pos runs 1..15 then 0; Light = 16'h0001 at Pos = 15 and back to 16'h8000; Tick high every cycle.
- REV, Div = 3, starting from reset → first Tick 4 cycles after release with Pos = 15 (Light = 16'h0001), next step Pos = 14 four cycles later.
- BOUNCE, Div = 0, WIDTH = 5 → Pos sequence 1,2,3,4,3,2,1,0,1.
- FWD with Style = 1, stepped to Pos = 3 → Light = 16'hF000; toggle Style to 0 → Light = 16'h1000 next cycle, Pos unchanged.
- FWD, Div = 9, at cnt = 5 switch to HOME for 1 cycle then back to FWD → Pos = 0 immediately; next Tick exactly 10 cycles after HOME ends; reset mid-run behaves identically.
